mult_seq_control: RTL and testbench

- FSM controller that sequences the shift-add multiplier datapath: register load, conditional add, shift, and completion.
- Contains its own iteration counter, which replaces the standalone Load/K counter for this path.
- Sits between the CPU's multiply issue logic (Start/Done/Busy) and the multiplier's product/multiplicand registers and adder.

---
 rtl/mult_seq_control_if.sv | 26 ++
 rtl/mult_seq_control.sv | 95 +++++++++
 tb/tb_mult_seq_control.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mult_seq_control_if.sv
// Handshake and strobe bundle between the multiply issue logic, the
// shift-add datapath and the sequencing controller.
interface mult_seq_control_if #(
   parameter int CNT_W = 6
);
   logic             Start;
   logic             Lsb;
   logic             Load_Regs;
   logic             Add_En;
   logic             Shift_En;
   logic             Busy;
   logic             Done;
   logic [CNT_W-1:0] Iter;

   // Controller side: consumes Start/Lsb, produces strobes and status.
   modport slave (
      input  Start, Lsb,
      output Load_Regs, Add_En, Shift_En, Busy, Done, Iter
   );

   // Issue logic / datapath side.
   modport master (
      output Start, Lsb,
      input  Load_Regs, Add_En, Shift_En, Busy, Done, Iter
   );
endinterface

// File: rtl/mult_seq_control.sv
// Sequencer for a shift-add multiplier: load, conditional add, shift,
// repeated WIDTH times, then a one-cycle Done pulse. Owns the iteration
// counter. All strobes are Moore outputs of the state register.
module mult_seq_control #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   mult_seq_control_if.slave    bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      TEST  = 3'd2,
      ADD   = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] iter;
   logic             last_iter;

   assign last_iter = (iter == LAST_ITER);
   assign bus.Iter  = iter;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Iteration counter: cleared in LOAD, advanced on every non-final SHIFT,
   // held on the final one so it never exceeds WIDTH-1.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         iter <= '0;
      end else if (state == LOAD) begin
         iter <= '0;
      end else if (state == SHIFT && !last_iter) begin
         iter <= iter + 1'b1;
      end
   end

   // Next-state and Moore strobe decode.
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt     = IDLE;
      bus.Load_Regs = 1'b0;
      bus.Add_En    = 1'b0;
      bus.Shift_En  = 1'b0;
      bus.Busy      = 1'b0;
      bus.Done      = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = bus.Start ? LOAD : IDLE;
         end
         LOAD: begin
            bus.Load_Regs = 1'b1;
            bus.Busy      = 1'b1;
            state_nxt     = TEST;
         end
         TEST: begin
            bus.Busy  = 1'b1;
            state_nxt = bus.Lsb ? ADD : SHIFT;
         end
         ADD: begin
            bus.Add_En = 1'b1;
            bus.Busy   = 1'b1;
            state_nxt  = SHIFT;
         end
         SHIFT: begin
            bus.Shift_En = 1'b1;
            bus.Busy     = 1'b1;
            state_nxt    = last_iter ? DONE : TEST;
         end
         DONE: begin
            bus.Done  = 1'b1;
            bus.Busy  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mult_seq_control.sv
// Self-checking bench: the controller drives a behavioural shift-add
// datapath; each operation is judged against arithmetic expectations
// (product, popcount-based latency, add positions from multiplier bits).
module tb_mult_seq_control;

   localparam int W     = 32;
   localparam int CNT_W = 6;

   logic Clk = 1'b0;
   logic Rst_n = 1'b1;

   mult_seq_control_if #(.CNT_W(CNT_W)) bus ();

   mult_seq_control #(.WIDTH(W), .CNT_W(CNT_W)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   // Behavioural product register and multiplicand.
   logic [2*W:0]   p;
   logic [W-1:0]   mcand;
   logic [W-1:0]   op_a, op_b;

   always @(posedge Clk) begin
      if (bus.Load_Regs === 1'b1) begin
         p     <= {{(W+1){1'b0}}, op_b};
         mcand <= op_a;
      end else if (bus.Add_En === 1'b1) begin
         p[2*W:W] <= {1'b0, p[2*W-1:W]} + {1'b0, mcand};
      end else if (bus.Shift_En === 1'b1) begin
         p <= p >> 1;
      end
   end

   assign bus.Lsb = p[0];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One multiply. mode 0: plain pulse; 1: extra Start pulse at Iter 10;
   // 2: Start held high through DONE, expecting exactly one IDLE cycle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
      int            cyc, loads, adds, shifts, done_at, max_iter, n_ones, exp_lat;
      logic [W-1:0]  add_mask;
      bit            onehot_ok, pair_ok, prev_add, pulsed;
      logic [63:0]   exp_prod;
      op_a = a; op_b = b;
      n_ones   = $countones(b);
      exp_lat  = 2 + 2*W + n_ones;
      exp_prod = 64'(a) * 64'(b);
      cyc = 0; loads = 0; adds = 0; shifts = 0; done_at = -1; max_iter = 0;
      add_mask = '0; onehot_ok = 1; pair_ok = 1; prev_add = 0; pulsed = 0;

      @(negedge Clk); bus.Start = 1'b1;
      @(negedge Clk);
      if (mode != 2) bus.Start = 1'b0;
      while (bus.Busy === 1'b1 && cyc < 400) begin
         cyc++;
         if ($countones({bus.Load_Regs, bus.Add_En, bus.Shift_En, bus.Done}) > 1) onehot_ok = 0;
         if (prev_add && bus.Shift_En !== 1'b1) pair_ok = 0;
         prev_add = (bus.Add_En === 1'b1);
         if (bus.Load_Regs === 1'b1) loads++;
         if (bus.Add_En === 1'b1) begin
            adds++;
            add_mask[bus.Iter[4:0]] = 1'b1;
         end
         if (bus.Shift_En === 1'b1) shifts++;
         if (bus.Done === 1'b1) done_at = cyc;
         if (int'(bus.Iter) > max_iter) max_iter = int'(bus.Iter);
         if (mode == 1) begin
            if (!pulsed && bus.Iter == 10) begin
               bus.Start = 1'b1;
               pulsed    = 1;
            end else begin
               bus.Start = 1'b0;
            end
         end
         @(negedge Clk);
      end
      check("no_timeout", 64'(cyc < 400), 64'd1);
      check("load_count", 64'(loads), 64'd1);
      check("add_count", 64'(adds), 64'(n_ones));
      check("shift_count", 64'(shifts), 64'(W));
      check("done_cycle", 64'(done_at), 64'(exp_lat));
      check("busy_cycles", 64'(cyc), 64'(exp_lat));
      check("add_positions", 64'(add_mask), 64'(b));
      check("one_hot", 64'(onehot_ok), 64'd1);
      check("add_then_shift", 64'(pair_ok), 64'd1);
      check("max_iter", 64'(max_iter), 64'(W-1));
      check("product", 64'(p[2*W-1:0]), exp_prod);
      check("idle_after", {62'd0, bus.Busy, bus.Done}, 64'd0);
      if (mode == 2) begin
         @(negedge Clk);
         check("hold_reload", {62'd0, bus.Busy, bus.Load_Regs}, 64'd3);
         bus.Start = 1'b0;
         cyc = 0;
         while (bus.Busy === 1'b1 && cyc < 400) begin
            cyc++;
            @(negedge Clk);
         end
         check("hold_second_latency", 64'(cyc), 64'(exp_lat));
         check("hold_second_product", 64'(p[2*W-1:0]), exp_prod);
      end
   endtask

   initial begin
      int guard;
      bus.Start = 1'b0;
      op_a = '0; op_b = '0;

      // Asynchronous reset asserted between clock edges.
      repeat (2) @(negedge Clk);
      #2 Rst_n = 1'b0;
      #1;
      check("rst_strobes", {59'd0, bus.Load_Regs, bus.Add_En, bus.Shift_En, bus.Busy, bus.Done}, 64'd0);
      check("rst_iter", 64'(bus.Iter), 64'd0);
      @(negedge Clk); Rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         check("idle_no_start", {62'd0, bus.Busy, bus.Load_Regs}, 64'd0);
      end

      // Directed corners: zero, all ones, sparse pattern.
      run_op(32'd7, 32'd0, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(32'd6, 32'd5, 0);
      run_op(32'h8000_0001, 32'h8000_0000, 0);

      // Randomized operands, dense and sparse multipliers.
      for (int i = 0; i < 6; i++) begin
         run_op($urandom, (i % 2 == 0) ? $urandom : ($urandom & $urandom & $urandom), 0);
      end

      // Start re-asserted mid-operation is ignored.
      run_op($urandom, $urandom, 1);

      // Start held through DONE re-launches after exactly one IDLE cycle.
      run_op($urandom, $urandom, 2);

      // Reset mid-operation at Iter 7 aborts immediately.
      op_a = $urandom; op_b = $urandom;
      @(negedge Clk); bus.Start = 1'b1;
      @(negedge Clk); bus.Start = 1'b0;
      guard = 0;
      while (bus.Iter != 7 && guard < 200) begin
         guard++;
         @(negedge Clk);
      end
      check("reach_iter7", 64'(guard < 200), 64'd1);
      #2 Rst_n = 1'b0;
      #1;
      check("midop_rst_strobes", {59'd0, bus.Load_Regs, bus.Add_En, bus.Shift_En, bus.Busy, bus.Done}, 64'd0);
      check("midop_rst_iter", 64'(bus.Iter), 64'd0);
      @(negedge Clk);
      check("midop_rst_held", 64'(bus.Busy), 64'd0);
      Rst_n = 1'b1;
      run_op($urandom, $urandom, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
